// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART responder.
// Register offsets, STATUS bit positions, minimum divisor and the TX/RX state encodings.
package uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_DIV    = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_IDLE    = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_RX_FRAME   = 4;
  localparam int ST_TX_DROP    = 5;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO; output data is a direct read of the head slot (zero latency).
// A push while full is accepted only when a pop frees the slot in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_uart_resp.sv
// 4-register MMIO UART (8N1): combinational same-cycle read data, zero when not selected.
// TX pushes into a small FIFO (push while full is dropped and flagged); RX holds one byte.
module mmio_uart_resp
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hC000,
  parameter logic [15:0] DEF_DIV    = 16'd434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic       sel;
  logic [1:0] off;
  logic       tx_push_req, sts_wr, div_wr, rx_rd;

  assign sel         = (addr[15:2] == BASE_ADDR[15:2]);
  assign off         = addr[1:0];
  assign tx_push_req = we & sel & (off == OFF_TXDATA);
  assign sts_wr      = we & sel & (off == OFF_STATUS);
  assign div_wr      = we & sel & (off == OFF_DIV);
  assign rx_rd       = re & sel & (off == OFF_RXDATA);

  logic [15:0] div_q;
  logic        rx_valid_q, rx_overrun_q, rx_frame_q, tx_drop_q;
  logic [7:0]  rx_byte_q;

  // TX FIFO
  logic          fifo_pop, fifo_push, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  assign fifo_push = tx_push_req & (~fifo_full | fifo_pop);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .din_i   (wdata[7:0]),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // TX FSM
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        tx_bit_end, tx_idle;

  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
  assign tx_idle    = (fifo_count == '0) & (tx_state_q == TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          tx_div_d   = eff_div(div_q);
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_dout;
            tx_div_d   = eff_div(div_q);
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    unique case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= MIN_DIV;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign txd = txd_q;

  // RX synchroniser and FSM
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_done_ok, rx_done_err, rx_bit_end;

  assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_done_ok  = 1'b0;
    rx_done_err = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q & ~rx_s2_q) begin
          rx_div_d   = eff_div(div_q);
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_bit_end) begin
          rx_cnt_d    = '0;
          rx_state_d  = RX_IDLE;
          rx_done_ok  = rx_s2_q;
          rx_done_err = ~rx_s2_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= MIN_DIV;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Flags: set events win over a same-cycle W1C.
  logic rx_valid_d, rx_overrun_d, rx_frame_d, tx_drop_d;
  logic [7:0] rx_byte_d;

  always_comb begin
    rx_byte_d    = rx_done_ok ? rx_shift_q : rx_byte_q;
    rx_valid_d   = rx_done_ok | (rx_valid_q & ~rx_rd);
    rx_overrun_d = (rx_done_ok & rx_valid_q & ~rx_rd)
                 | (rx_overrun_q & ~(sts_wr & wdata[ST_RX_OVERRUN]));
    rx_frame_d   = rx_done_err | (rx_frame_q & ~(sts_wr & wdata[ST_RX_FRAME]));
    tx_drop_d    = (tx_push_req & fifo_full & ~fifo_pop)
                 | (tx_drop_q & ~(sts_wr & wdata[ST_TX_DROP]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= DEF_DIV;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_frame_q   <= 1'b0;
      tx_drop_q    <= 1'b0;
    end else begin
      if (div_wr) div_q <= wdata;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      rx_frame_q   <= rx_frame_d;
      tx_drop_q    <= tx_drop_d;
    end
  end

  assign irq = rx_valid_q;

  always_comb begin
    rdata = '0;
    if (re & sel) begin
      unique case (off)
        OFF_RXDATA: rdata = {8'h00, rx_byte_q};
        OFF_STATUS: rdata = {10'd0, tx_drop_q, rx_frame_q, rx_overrun_q,
                             rx_valid_q, tx_idle, fifo_full};
        OFF_DIV:    rdata = div_q;
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_resp.sv
// Directed bench for mmio_uart_resp: register-access vector table plus serial TX/RX sequences.
module tb_mmio_uart_resp;

  logic        clk = 1'b0;
  logic        rst, we, re, rxd;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        txd, irq;

  mmio_uart_resp dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] txq[$];
  int         mon_div = 4;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    re = 1'b1; addr = a;
    #1 d = rdata;
    @(posedge clk);
    #1 re = 1'b0; addr = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] v;
    bus_rd(a, v);
    chk(nm, v, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, input int div);
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (div) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (div) @(posedge clk);
      #1;
    end
    rxd = stopb;
    repeat (div) @(posedge clk);
    #1 rxd = 1'b1;
  endtask

  // Cycle-exact check of one TX frame starting at the next low txd.
  task automatic tx_frame(input string nm, input logic [7:0] b, input int div);
    int         errs;
    bit         found;
    logic [9:0] fr;
    logic [7:0] mid;
    errs  = 0;
    found = 1'b0;
    mid   = '0;
    fr    = {1'b1, b, 1'b0};
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    chk({nm, "_start"}, 16'(found), 16'd1);
    if (found) begin
      for (int i = 0; i < 10; i++) begin
        for (int j = 0; j < div; j++) begin
          if (i != 0 || j != 0) @(negedge clk);
          if (txd !== fr[i]) errs++;
          if (j == div / 2 && i >= 1 && i <= 8) mid[i-1] = txd;
        end
      end
      chk({nm, "_bit_cycles"}, 16'(errs), 16'd0);
      chk({nm, "_byte"}, {8'h00, mid}, {8'h00, b});
    end
  endtask

  // Background serial decoder of txd into txq.
  initial begin
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        repeat (mon_div / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (mon_div) @(negedge clk);
          b = {txd, b[7:1]};
        end
        repeat (mon_div) @(negedge clk);
        if (txd === 1'b1) txq.push_back(b);
      end
    end
  end

  initial begin
    logic [15:0] v;
    int          cal;
    int          lows;
    logic [7:0]  exp_bytes[5];

    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; rxd = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", {15'd0, txd}, 16'd1);
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_rdata", rdata, 16'd0);
    rst = 1'b0;

    //           we    re    addr      wdata     chk   exp
    tbl[0]  = '{1'b0, 1'b1, 16'hC002, 16'h0000, 1'b1, 16'h0002};
    tbl[1]  = '{1'b0, 1'b1, 16'hC003, 16'h0000, 1'b1, 16'd434};
    tbl[2]  = '{1'b0, 1'b1, 16'hC001, 16'h0000, 1'b1, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 16'hC000, 16'h0000, 1'b1, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 16'hC003, 16'h1234, 1'b1, 16'h0000};
    tbl[5]  = '{1'b0, 1'b1, 16'hC003, 16'h0000, 1'b1, 16'h1234};
    tbl[6]  = '{1'b0, 1'b1, 16'hC004, 16'h0000, 1'b1, 16'h0000};
    tbl[7]  = '{1'b0, 1'b1, 16'h8002, 16'h0000, 1'b1, 16'h0000};
    tbl[8]  = '{1'b0, 1'b0, 16'hC003, 16'h0000, 1'b1, 16'h0000};
    tbl[9]  = '{1'b1, 1'b1, 16'hC003, 16'h0002, 1'b1, 16'h1234};
    tbl[10] = '{1'b0, 1'b1, 16'hC003, 16'h0000, 1'b1, 16'h0002};
    tbl[11] = '{1'b1, 1'b0, 16'hC002, 16'hFFFF, 1'b0, 16'h0000};
    tbl[12] = '{1'b0, 1'b1, 16'hC002, 16'h0000, 1'b1, 16'h0002};
    tbl[13] = '{1'b0, 1'b1, 16'hC007, 16'h0000, 1'b1, 16'h0000};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      we = tbl[i].we; re = tbl[i].re; addr = tbl[i].addr; wdata = tbl[i].wdata;
      #1;
      if (tbl[i].chk) chk($sformatf("vec%0d", i), rdata, tbl[i].exp);
      @(posedge clk);
      #1 we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    end

    // DIV=2 is clamped to 4 cycles per bit.
    bus_wr(16'hC000, 16'h0055);
    tx_frame("tx_div2", 8'h55, 4);

    bus_wr(16'hC003, 16'd4);
    bus_wr(16'hC000, 16'h0055);
    rd_chk("tx_busy_status", 16'hC002, 16'h0000);
    tx_frame("tx_div4", 8'h55, 4);
    rd_chk("tx_idle_status", 16'hC002, 16'h0002);

    // FIFO full and drop while the shifter is busy.
    repeat (10) @(posedge clk);
    txq.delete();
    exp_bytes[0] = 8'h31; exp_bytes[1] = 8'h41; exp_bytes[2] = 8'h42;
    exp_bytes[3] = 8'h43; exp_bytes[4] = 8'h44;
    bus_wr(16'hC000, 16'h0031);
    for (int i = 0; i < 5; i++) bus_wr(16'hC000, 16'h0041 + 16'(i));
    rd_chk("fifo_full_drop", 16'hC002, 16'h0021);
    bus_wr(16'hC002, 16'h0020);
    rd_chk("drop_cleared", 16'hC002, 16'h0001);
    for (int k = 0; k < 1500 && txq.size() < 5; k++) @(negedge clk);
    repeat (60) @(negedge clk);
    chk("fifo_tx_count", 16'(txq.size()), 16'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < txq.size()) chk($sformatf("fifo_byte%0d", i), {8'h00, txq[i]}, {8'h00, exp_bytes[i]});
    end
    rd_chk("fifo_drained", 16'hC002, 16'h0002);

    // RX basic.
    bus_wr(16'hC003, 16'd8);
    chk("irq_before_rx", {15'd0, irq}, 16'd0);
    send_rx(8'hA3, 1'b1, 8);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("irq_after_rx", {15'd0, irq}, 16'd1);
    rd_chk("rx_a3", 16'hC001, 16'h00A3);
    chk("irq_cleared", {15'd0, irq}, 16'd0);

    // Completion coinciding with an RXDATA read.
    repeat (5) @(posedge clk);
    #2;
    cal = 0;
    fork
      send_rx(8'h3C, 1'b1, 8);
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (irq === 1'b1) begin
            cal = k + 1;
            break;
          end
        end
      end
    join
    chk("rx_cal_found", 16'(cal >= 3), 16'd1);
    if (cal >= 3) begin
      repeat (5) @(posedge clk);
      #2;
      v = '0;
      fork
        send_rx(8'hC5, 1'b1, 8);
        begin
          repeat (cal - 2) @(negedge clk);
          bus_rd(16'hC001, v);
        end
      join
      chk("simul_old_byte", v, 16'h003C);
      rd_chk("simul_status", 16'hC002, 16'h0006);
      rd_chk("simul_new_byte", 16'hC001, 16'h00C5);
    end

    // Overrun, frame error, glitch.
    send_rx(8'h11, 1'b1, 8);
    repeat (2) @(posedge clk);
    send_rx(8'h22, 1'b1, 8);
    repeat (4) @(posedge clk);
    rd_chk("overrun_status", 16'hC002, 16'h000E);
    rd_chk("overrun_byte", 16'hC001, 16'h0022);
    send_rx(8'h5A, 1'b0, 8);
    repeat (4) @(posedge clk);
    rd_chk("frame_err_status", 16'hC002, 16'h001A);
    rd_chk("frame_err_byte", 16'hC001, 16'h0022);
    chk("frame_err_irq", {15'd0, irq}, 16'd0);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (30) @(posedge clk);
    rd_chk("glitch_status", 16'hC002, 16'h001A);
    bus_wr(16'hC002, 16'h0018);
    rd_chk("w1c_rx_flags", 16'hC002, 16'h0002);

    // Reset in the middle of a TX frame.
    bus_wr(16'hC003, 16'd4);
    bus_wr(16'hC000, 16'h0000);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("txd_mid_frame", {15'd0, txd}, 16'd0);
    rst = 1'b1;
    #1;
    chk("txd_async_rst", {15'd0, txd}, 16'd1);
    chk("irq_async_rst", {15'd0, irq}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_chk("rst2_status", 16'hC002, 16'h0002);
    rd_chk("rst2_div", 16'hC003, 16'd434);
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("txd_idle_after_rst", 16'(lows), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
